key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Debounces the enter/change pushbuttons and captures the code switches on each
// accepted press, producing single-cycle pulses for the downstream lock FSM.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       enter_btn,
  input  logic       change_btn,
  input  logic [3:0] sw,
  output logic       enter,
  output logic       change,
  output logic [3:0] userpass
);

  localparam int unsigned     NumBtn = 2;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StHeld, StRel} state_e;

  // Two-flop synchronizers, packed as {sw, change_btn, enter_btn}.
  logic [5:0] meta_q, sync_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {sw, change_btn, enter_btn};
      sync_q <= meta_q;
    end
  end

  logic [NumBtn-1:0] btn_sync;
  logic [3:0]        sw_sync;

  assign btn_sync = sync_q[1:0];
  assign sw_sync  = sync_q[5:2];

  // Per-button debounce FSMs; index 0 is enter, index 1 is change.
  state_e            state_q [NumBtn];
  state_e            state_d [NumBtn];
  logic [CNT_W-1:0]  cnt_q   [NumBtn];
  logic [CNT_W-1:0]  cnt_d   [NumBtn];
  logic [NumBtn-1:0] fire;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NumBtn; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NumBtn; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    fire = '0;
    for (int i = 0; i < NumBtn; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (btn_sync[i]) begin
            state_d[i] = StArm;
            cnt_d[i]   = '0;
          end
        end
        StArm: begin
          if (!btn_sync[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StHeld;
            fire[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StHeld: begin
          if (!btn_sync[i]) begin
            state_d[i] = StRel;
            cnt_d[i]   = '0;
          end
        end
        StRel: begin
          // A re-press during release debounce returns to HELD without a pulse.
          if (btn_sync[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Registered outputs; enter wins a same-edge tie and the change pulse is dropped.
  logic       enter_q, enter_d;
  logic       change_q, change_d;
  logic [3:0] userpass_q, userpass_d;

  always_comb begin
    enter_d    = fire[0];
    change_d   = fire[1] & ~fire[0];
    userpass_d = (|fire) ? sw_sync : userpass_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      enter_q    <= 1'b0;
      change_q   <= 1'b0;
      userpass_q <= 4'b0000;
    end else begin
      enter_q    <= enter_d;
      change_q   <= change_d;
      userpass_q <= userpass_d;
    end
  end

  assign enter    = enter_q;
  assign change   = change_q;
  assign userpass = userpass_q;

endmodule
